// File: rtl/control_sequencer.sv
// control_sequencer: instruction register, micro-step counter and run/halt/fault
// state for the control unit. Consumes the decoder's II/ADV/HLT bits and adds
// halt/resume, runaway-step fault detection and a wrapping retired counter.
// Optional build macro: SINGLE_STEP_EN adds the PAUSE state and the
// i_step_mode / i_step_req / o_step_ack debugger handshake.
module control_sequencer #(
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned INSTRUCTION_STEPS = 32,
    parameter int unsigned RETIRED_WIDTH     = 32,
    localparam int unsigned STEP_WIDTH       = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [INSTRUCTION_WIDTH-1:0] i_bus,
    input  logic                         i_ii,
    input  logic                         i_adv,
    input  logic                         i_hlt,
    input  logic                         i_resume,
`ifdef SINGLE_STEP_EN
    input  logic                         i_step_mode,
    input  logic                         i_step_req,
    output logic                         o_step_ack,
`endif
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic                         o_run,
    output logic                         o_halted,
    output logic                         o_fault,
    output logic [RETIRED_WIDTH-1:0]     o_retired
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
`endif

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    state_t state;

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_RUN;
            o_instruction <= '0;
            o_step        <= '0;
            o_retired     <= '0;
            o_run         <= 1'b1;
            o_halted      <= 1'b0;
            o_fault       <= 1'b0;
`ifdef SINGLE_STEP_EN
            o_step_ack    <= 1'b0;
`endif
        end else begin
`ifdef SINGLE_STEP_EN
            o_step_ack <= 1'b0;
`endif
            case (state)
                ST_RUN: begin
                    // Instruction load is independent of the step/state branches below.
                    if (i_ii) begin
                        o_instruction <= i_bus;
                    end
                    if (i_hlt) begin
                        state    <= ST_HALT;
                        o_run    <= 1'b0;
                        o_halted <= 1'b1;
                    end else if (i_adv) begin
                        o_step    <= '0;
                        o_retired <= o_retired + RETIRED_WIDTH'(1);
`ifdef SINGLE_STEP_EN
                        if (i_step_mode) begin
                            state <= ST_PAUSE;
                            o_run <= 1'b0;
                        end
`endif
                    end else if (o_step == LAST_STEP) begin
                        state    <= ST_FAULT;
                        o_fault  <= 1'b1;
                        o_run    <= 1'b0;
                        o_halted <= 1'b1;
                    end else begin
                        o_step <= o_step + STEP_WIDTH'(1);
                    end
                end
                ST_HALT: begin
                    // Resuming retires the instruction that issued HLT.
                    if (i_resume) begin
                        state     <= ST_RUN;
                        o_step    <= '0;
                        o_retired <= o_retired + RETIRED_WIDTH'(1);
                        o_run     <= 1'b1;
                        o_halted  <= 1'b0;
                    end
                end
`ifdef SINGLE_STEP_EN
                ST_PAUSE: begin
                    if (i_step_req) begin
                        state      <= ST_RUN;
                        o_run      <= 1'b1;
                        o_step_ack <= 1'b1;
                    end else if (!i_step_mode) begin
                        state <= ST_RUN;
                        o_run <= 1'b1;
                    end
                end
`endif
                default: begin
                    // FAULT is absorbing until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver pushes hand-computed
// expected output snapshots tagged with the cycle they apply to; the monitor
// pops and compares them on the falling edge of that cycle.
module tb_control_sequencer;

    localparam int unsigned IW = 16;
    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] bus;
    logic          ii, adv, hlt, resume;
    logic [IW-1:0] instruction;
    logic [4:0]    step;
    logic          run, halted, fault;
    logic [RW-1:0] retired;
`ifdef SINGLE_STEP_EN
    logic          step_mode, step_req, step_ack;
`endif

    control_sequencer #(
        .INSTRUCTION_WIDTH(IW),
        .INSTRUCTION_STEPS(32),
        .RETIRED_WIDTH(RW)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_bus(bus),
        .i_ii(ii),
        .i_adv(adv),
        .i_hlt(hlt),
        .i_resume(resume),
`ifdef SINGLE_STEP_EN
        .i_step_mode(step_mode),
        .i_step_req(step_req),
        .o_step_ack(step_ack),
`endif
        .o_instruction(instruction),
        .o_step(step),
        .o_run(run),
        .o_halted(halted),
        .o_fault(fault),
        .o_retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        string         name;
        logic [IW-1:0] instr;
        logic [4:0]    stp;
        logic          run;
        logic          halted;
        logic          fault;
        logic [RW-1:0] ret;
        logic          ack;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle_no = 0;
    int          total = 0;
    int          bad = 0;

    logic [IW-1:0] e_instr;
    logic [4:0]    e_step;
    logic          e_run, e_halted, e_fault, e_ack;
    logic [RW-1:0] e_ret;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, fld, act, exp, cycle_no);
        end
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle_no) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cycle_no) begin
                total++;
                bad++;
                $display("FAIL %s: expectation for cycle %0d missed, now %0d", e.name, e.cyc, cycle_no);
            end else begin
                chk(e.name, "instruction", 32'(instruction), 32'(e.instr));
                chk(e.name, "step",        32'(step),        32'(e.stp));
                chk(e.name, "run",         32'(run),         32'(e.run));
                chk(e.name, "halted",      32'(halted),      32'(e.halted));
                chk(e.name, "fault",       32'(fault),       32'(e.fault));
                chk(e.name, "retired",     32'(retired),     32'(e.ret));
`ifdef SINGLE_STEP_EN
                chk(e.name, "step_ack",    32'(step_ack),    32'(e.ack));
`endif
            end
        end
    end

    task automatic push_exp(input int unsigned c, input string nm);
        exp_t e;
        e.cyc    = c;
        e.name   = nm;
        e.instr  = e_instr;
        e.stp    = e_step;
        e.run    = e_run;
        e.halted = e_halted;
        e.fault  = e_fault;
        e.ret    = e_ret;
        e.ack    = e_ack;
        sb.push_back(e);
    endtask

    task automatic set_reset_exp();
        e_instr  = '0;
        e_step   = '0;
        e_run    = 1'b1;
        e_halted = 1'b0;
        e_fault  = 1'b0;
        e_ret    = '0;
        e_ack    = 1'b0;
    endtask

    // Drive one cycle of control word; e_* already hold the post-edge expectation.
    task automatic tick(input logic v_ii, input logic v_adv, input logic v_hlt, input logic v_res, input string nm);
        ii     = v_ii;
        adv    = v_adv;
        hlt    = v_hlt;
        resume = v_res;
        push_exp(cycle_no + 1, nm);
        @(posedge clk);
        #1;
    endtask

    // Reset pulse entirely between two rising edges: only an asynchronous
    // reset takes effect, and the following edge then advances to step 1.
    task automatic pulse_reset(input string nm);
        ii = 1'b0; adv = 1'b0; hlt = 1'b0; resume = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        set_reset_exp();
        e_step = 5'd1;
        push_exp(cycle_no + 1, nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; bus = '0; ii = 1'b0; adv = 1'b0; hlt = 1'b0; resume = 1'b0;
`ifdef SINGLE_STEP_EN
        step_mode = 1'b0; step_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_reset_exp();
        push_exp(cycle_no, "reset");

        // Fetch 0x002a at step 1, end at step 3.
        bus = 16'h002a;
        e_step = 5'd1;                        tick(0, 0, 0, 0, "t1_s1");
        e_step = 5'd2; e_instr = 16'h002a;    tick(1, 0, 0, 0, "t1_fetch");
        e_step = 5'd3;                        tick(0, 0, 0, 0, "t1_s3");
        e_step = 5'd0; e_ret = 4'd1;          tick(0, 1, 0, 0, "t1_adv");

        // HLT at step 2, held 10 cycles with ignored strobes, then resume.
        e_step = 5'd1;                        tick(0, 0, 0, 0, "t2_s1");
        e_step = 5'd2;                        tick(0, 0, 0, 0, "t2_s2");
        e_run = 1'b0; e_halted = 1'b1;        tick(0, 0, 1, 0, "t2_hlt");
        bus = 16'hbeef;
        for (int i = 0; i < 10; i++) begin
            tick(logic'(i % 2 == 0), logic'(i % 3 == 0), logic'(i % 4 == 0), 0, "t2_held");
        end
        e_step = 5'd0; e_run = 1'b1; e_halted = 1'b0; e_ret = 4'd2;
        tick(0, 0, 0, 1, "t2_resume");
        e_step = 5'd1;                        tick(0, 0, 0, 1, "t2_resume_in_run");

        // HLT and ADV together: HALT wins, no retire.
        e_run = 1'b0; e_halted = 1'b1;        tick(0, 1, 1, 0, "t4_hlt_adv");
        e_step = 5'd0; e_run = 1'b1; e_halted = 1'b0; e_ret = 4'd3;
        tick(0, 0, 0, 1, "t4_resume");

        // Retired counter wrap (4-bit): 4..15, then 0 with a same-edge load.
        bus = 16'h1234;
        for (int i = 0; i < 12; i++) begin
            e_ret = RW'(4 + i);
            tick(0, 1, 0, 0, "t5_count");
        end
        e_ret = 4'd0; e_instr = 16'h1234;     tick(1, 1, 0, 0, "t5_wrap");

        // Mid-instruction reset.
        bus = 16'h00ff;
        e_step = 5'd1;                        tick(0, 0, 0, 0, "t6_s1");
        e_step = 5'd2; e_instr = 16'h00ff;    tick(1, 0, 0, 0, "t6_fetch");
        pulse_reset("t6_reset");

        // Runaway: no ADV until the last step, then FAULT is absorbing.
        for (int s = 2; s <= 31; s++) begin
            e_step = 5'(s);
            tick(0, 0, 0, 0, "t3_run");
        end
        e_fault = 1'b1; e_halted = 1'b1; e_run = 1'b0;
        tick(0, 0, 0, 0, "t3_fault");
        bus = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 1, 1, "t3_absorb");
        end
        pulse_reset("t3_reset");

`ifdef SINGLE_STEP_EN
        // Single-step: pause after ADV, release one instruction with req/ack.
        step_mode = 1'b1;
        e_step = 5'd0; e_ret = 4'd1; e_run = 1'b0;
        tick(0, 1, 0, 0, "p_pause");
        bus = 16'h5555;
        tick(1, 1, 1, 0, "p_ignore");
        step_req = 1'b1;
        e_run = 1'b1; e_ack = 1'b1;           tick(0, 0, 0, 0, "p_req");
        step_req = 1'b0;
        e_ack = 1'b0; e_step = 5'd1;          tick(0, 0, 0, 0, "p_exec1");
        e_step = 5'd2;                        tick(0, 0, 0, 0, "p_exec2");
        e_step = 5'd0; e_ret = 4'd2; e_run = 1'b0;
        tick(0, 1, 0, 0, "p_pause2");
        tick(0, 0, 0, 0, "p_still_paused");
        step_mode = 1'b0;
        e_run = 1'b1;                         tick(0, 0, 0, 0, "p_mode_off");
        e_step = 5'd1;                        tick(0, 0, 0, 0, "p_run_free");
`endif

        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
